// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor core operand loader: operand/matrix types, op codes and loader states.
package tensor_core_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned MAT_ELEMS  = 9;
  localparam int unsigned SET_ELEMS  = 2 * MAT_ELEMS;

  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [2:0][2:0] matrix3_t;

  typedef enum logic [2:0] {
    OP_MATMUL = 3'b000,
    OP_ADD    = 3'b001,
    OP_RELU   = 3'b010
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_START,
    ST_COMPUTE,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/tensor_core_operand_stage.sv
// Staging buffer: assembles 18 streamed operands (A then B, row-major) and the set's op code.
module tensor_core_operand_stage
  import tensor_core_pkg::*;
(
  input  logic       tensor_core_clock,
  input  logic       reset_n_in,
  input  logic       in_valid,
  input  elem_t      in_data,
  input  logic [2:0] in_op,
  input  logic       clear,
  output logic       in_ready,
  output logic       full,
  output matrix3_t   stage_a,
  output matrix3_t   stage_b,
  output logic [2:0] stage_op
);

  logic [4:0] stage_count;
  logic [4:0] base_idx;
  logic       ready_en;
  logic       accept;

  // ready_en keeps in_ready low during the reset cycle itself
  assign in_ready = ready_en && (stage_count < 5'(SET_ELEMS));
  assign full     = (stage_count == 5'(SET_ELEMS));
  assign accept   = in_valid && in_ready;
  // clear wins over the running count, so an element taken on the commit edge lands at index 0
  assign base_idx = clear ? '0 : stage_count;

  always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ready_en    <= 1'b0;
      stage_count <= '0;
      stage_a     <= '0;
      stage_b     <= '0;
      stage_op    <= '0;
    end else begin
      ready_en    <= 1'b1;
      stage_count <= base_idx + 5'(accept);
      if (accept) begin
        if (base_idx == '0) stage_op <= in_op;
        for (int unsigned r = 0; r < 3; r++) begin
          for (int unsigned c = 0; c < 3; c++) begin
            if (base_idx == 5'(r * 3 + c))
              stage_a[2'(r)][2'(c)] <= in_data;
            if (base_idx == 5'(MAT_ELEMS + r * 3 + c))
              stage_b[2'(r)][2'(c)] <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tensor_core_operand_loader.sv
// Operand loader for small_tensor_core: double-buffered staging, committed operand registers and
// the clear/start/compute/result sequencing of the core.
module tensor_core_operand_loader #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned COMPUTE_CYCLES = 9
) (
  input  logic                          tensor_core_clock,
  input  logic                          reset_n_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic [2:0]                    in_op,
  output tensor_core_pkg::matrix3_t     tensor_core_input1,
  output tensor_core_pkg::matrix3_t     tensor_core_input2,
  output logic [2:0]                    matrix_operation_select,
  output logic                          tensor_core_register_file_write_enable,
  output logic                          should_start_tensor_core,
  output logic                          busy,
  output logic                          result_valid
);

  import tensor_core_pkg::*;

  loader_state_e state;
  logic [3:0]    compute_count;
  logic          stage_full;
  logic          commit;
  matrix3_t      stage_a;
  matrix3_t      stage_b;
  logic [2:0]    stage_op;

  assign commit = (state == ST_IDLE) && stage_full;

  tensor_core_operand_stage u_stage (
    .tensor_core_clock (tensor_core_clock),
    .reset_n_in        (reset_n_in),
    .in_valid          (in_valid),
    .in_data           (elem_t'(in_data)),
    .in_op             (in_op),
    .clear             (commit),
    .in_ready          (in_ready),
    .full              (stage_full),
    .stage_a           (stage_a),
    .stage_b           (stage_b),
    .stage_op          (stage_op)
  );

  // Pulses are registered on the edge entering their state, so each lasts exactly that state's cycle.
  always_ff @(posedge tensor_core_clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state                                  <= ST_IDLE;
      compute_count                          <= '0;
      tensor_core_input1                     <= '0;
      tensor_core_input2                     <= '0;
      matrix_operation_select                <= '0;
      tensor_core_register_file_write_enable <= 1'b0;
      should_start_tensor_core               <= 1'b0;
      busy                                   <= 1'b0;
      result_valid                           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit) begin
            tensor_core_input1                     <= stage_a;
            tensor_core_input2                     <= stage_b;
            matrix_operation_select                <= stage_op;
            tensor_core_register_file_write_enable <= 1'b1;
            busy                                   <= 1'b1;
            state                                  <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          tensor_core_register_file_write_enable <= 1'b0;
          should_start_tensor_core               <= 1'b1;
          state                                  <= ST_START;
        end
        ST_START: begin
          should_start_tensor_core <= 1'b0;
          compute_count            <= '0;
          state                    <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (compute_count == 4'(COMPUTE_CYCLES - 1)) begin
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end else begin
            compute_count <= compute_count + 4'd1;
          end
        end
        ST_DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_operand_loader.sv
// Directed self-checking bench for tensor_core_operand_loader.
module tb_tensor_core_operand_loader;

  import tensor_core_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic [2:0]        in_op = '0;
  matrix3_t          in1, in2;
  logic [2:0]        op_sel;
  logic              we, start, busy, rv;

  int unsigned tests = 0;
  int unsigned fails = 0;

  tensor_core_operand_loader #(
    .DATA_WIDTH     (8),
    .COMPUTE_CYCLES (9)
  ) dut (
    .tensor_core_clock                      (clk),
    .reset_n_in                             (rst_n),
    .in_valid                               (in_valid),
    .in_ready                               (in_ready),
    .in_data                                (in_data),
    .in_op                                  (in_op),
    .tensor_core_input1                     (in1),
    .tensor_core_input2                     (in2),
    .matrix_operation_select                (op_sel),
    .tensor_core_register_file_write_enable (we),
    .should_start_tensor_core               (start),
    .busy                                   (busy),
    .result_valid                           (rv)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic matrix3_t mk_seq(input int base, input int step);
    matrix3_t m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[2'(r)][2'(c)] = 8'(base + step * (r * 3 + c));
    return m;
  endfunction

  function automatic matrix3_t mk_ident();
    matrix3_t m;
    m = '0;
    for (int i = 0; i < 3; i++) m[2'(i)][2'(i)] = 8'sd1;
    return m;
  endfunction

  function automatic logic [7:0] elem_of(input matrix3_t a, input matrix3_t b, input int k);
    if (k < 9) return a[2'(k / 3)][2'(k % 3)];
    return b[2'((k - 9) / 3)][2'((k - 9) % 3)];
  endfunction

  // Presents one element and holds it until accepted (bounded).
  task automatic send_elem(input logic [7:0] d, input logic [2:0] op);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_set(input matrix3_t a, input matrix3_t b, input logic [2:0] op0, input bit gap);
    for (int k = 0; k < 18; k++) begin
      send_elem(elem_of(a, b, k), (k == 0) ? op0 : (op0 ^ 3'(1 + k % 7)));
      if (gap && k < 17) tick();
    end
  endtask

  // Called right after the edge accepting the 18th element while the loader is IDLE.
  task automatic run_seq(input string tag, input matrix3_t ea, input matrix3_t eb, input logic [2:0] eop);
    int unsigned busy_n, rv_n;
    busy_n = 0;
    rv_n   = 0;
    for (int c = 1; c <= 14; c++) begin
      busy_n += 32'(busy);
      rv_n   += 32'(rv);
      chk({tag, "_we"},    we,    c == 2);
      chk({tag, "_start"}, start, c == 3);
      chk({tag, "_rv"},    rv,    c == 13);
      chk({tag, "_busy"},  busy,  (c >= 2 && c <= 13));
      if (c >= 2 && c <= 13) begin
        chk({tag, "_in1"}, in1,    ea);
        chk({tag, "_in2"}, in2,    eb);
        chk({tag, "_op"},  op_sel, eop);
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, busy_n, 12);
    chk({tag, "_rv_pulses"},   rv_n,   1);
  endtask

  matrix3_t a1, b1, a2, b2;
  int unsigned rv_n, wait_n;

  initial begin
    // reset
    #2 rst_n = 1'b0;
    #2;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we",    we,       1'b0);
    chk("rst_start", start,    1'b0);
    chk("rst_busy",  busy,     1'b0);
    chk("rst_rv",    rv,       1'b0);
    chk("rst_in1",   in1,      '0);
    chk("rst_op",    op_sel,   '0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rel_ready0", in_ready, 1'b0);
    tick();
    chk("rel_ready1", in_ready, 1'b1);

    // 1: identity x 1..9, matmul, back-to-back
    send_set(mk_ident(), mk_seq(1, 1), OP_MATMUL, 1'b0);
    run_seq("t1", mk_ident(), mk_seq(1, 1), 3'b000);

    // 2: all-100 operands, add
    send_set(mk_seq(100, 0), mk_seq(100, 0), OP_ADD, 1'b0);
    run_seq("t2", mk_seq(100, 0), mk_seq(100, 0), 3'b001);

    // 3: second set streams in while the first one is sequenced
    a1 = mk_seq(3, 5);
    b1 = mk_seq(-20, 4);
    a2 = mk_seq(-128, 31);
    b2 = mk_seq(127, -1);
    send_set(a1, b1, OP_RELU, 1'b0);
    chk("t3_idle_we", we, 1'b0);
    tick();
    chk("t3_commit_we", we, 1'b1);
    rv_n = 0;
    for (int k = 0; k < 18; k++) begin
      chk("t3_ready_open", in_ready, 1'b1);
      chk("t3_in1_hold",   in1,      a1);
      chk("t3_in2_hold",   in2,      b1);
      rv_n += 32'(rv);
      in_valid = 1'b1;
      in_data  = elem_of(a2, b2, k);
      in_op    = (k == 0) ? 3'b001 : 3'b110;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_rv_once",     rv_n,     1);
    chk("t3_ready_full",  in_ready, 1'b0);
    chk("t3_wait_we",     we,       1'b0);
    chk("t3_wait_busy",   busy,     1'b0);
    chk("t3_wait_in1",    in1,      a1);
    tick();
    chk("t3_c2_we",    we,       1'b1);
    chk("t3_c2_in1",   in1,      a2);
    chk("t3_c2_in2",   in2,      b2);
    chk("t3_c2_op",    op_sel,   3'b001);
    chk("t3_c2_ready", in_ready, 1'b1);
    wait_n = 0;
    while (!rv && wait_n < 30) begin
      tick();
      wait_n++;
    end
    chk("t3_c2_rv", rv, 1'b1);
    chk("t3_c2_rv_lat", wait_n, 11);
    tick();

    // 4: gapped stream, op noise on elements 1..17
    send_set(mk_seq(-9, 2), mk_seq(50, -13), OP_RELU, 1'b1);
    run_seq("t4", mk_seq(-9, 2), mk_seq(50, -13), 3'b010);

    // 5: reset during compute with a partial new set staged
    send_set(mk_ident(), mk_seq(1, 1), OP_MATMUL, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) send_elem(8'(60 + k), 3'b011);
    chk("t5_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_we",    we,       1'b0);
    chk("t5_start", start,    1'b0);
    chk("t5_busy",  busy,     1'b0);
    chk("t5_rv",    rv,       1'b0);
    chk("t5_in1",   in1,      '0);
    chk("t5_in2",   in2,      '0);
    chk("t5_op",    op_sel,   '0);
    chk("t5_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_rel_ready", in_ready, 1'b1);
    send_set(mk_seq(-1, -3), mk_seq(7, 7), OP_ADD, 1'b0);
    run_seq("t5", mk_seq(-1, -3), mk_seq(7, 7), 3'b001);

    // 6: reserved op code still sequenced
    send_set(mk_seq(2, 2), mk_seq(-2, -2), 3'b111, 1'b0);
    run_seq("t6", mk_seq(2, 2), mk_seq(-2, -2), 3'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
